// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, frame width and receiver state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;  // 115200 baud at 50 MHz
  localparam int FRAME_BITS       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchronizer for the asynchronous serial line.
// Flops reset to 1 so that the idle-high line produces no false edge on reset release.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, centre-samples each bit, and reports
// a received byte or a framing error with one-cycle pulses.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on the synchronized rx
// ST_START | counting to mid start bit to reject glitches (false starts)
// ST_DATA  | sampling 8 data bits, LSB first, one per bit period
// ST_STOP  | sampling the stop bit; high delivers the byte, low flags error
// ST_BREAK | line held low after a framing error; wait for it to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  logic rx_s;

  rx_state_t             state, state_next;
  logic [CNT_W-1:0]      baud_cnt, cnt_next;
  logic [BIT_W-1:0]      bit_idx, bit_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [7:0]            data_next;
  logic                  dv_next, fe_next;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= cnt_next;
      bit_idx    <= bit_next;
      shift_reg  <= shift_next;
      data       <= data_next;
      data_valid <= dv_next;
      frame_err  <= fe_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    data_next  = data;
    dv_next    = 1'b0;
    fe_next    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end

      ST_START: begin
        if (baud_cnt == HALF_CNT) begin
          cnt_next   = '0;
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = baud_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_cnt == LAST_CNT) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = baud_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_cnt == LAST_CNT) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            dv_next    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = ST_BREAK;
          end
        end else begin
          cnt_next = baud_cnt + 1'b1;
        end
      end

      ST_BREAK: begin
        // Start detection is suppressed until the line has returned high.
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
